// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order imem requests under a credit limit, buffers words for decode.
// Response-to-instruction_valid latency is one cycle; stall holds the head, and credits stop requests once the buffer plus in-flight reaches FIFO_DEPTH.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output logic [31:0] instruction,
    output logic [31:0] instruction_pc,
    output logic        instruction_valid
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   data_mem_q [FIFO_DEPTH];
    logic [31:0]   data_mem_d [FIFO_DEPTH];
    logic [31:0]   pc_mem_q   [FIFO_DEPTH];
    logic [31:0]   pc_mem_d   [FIFO_DEPTH];

    logic          credit_ok;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [31:0]   target;

    assign credit_ok      = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C;
    assign imem_req_valid = reset_n & credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign target         = redirect_target & 32'hFFFF_FFFC;
    // Words still owed to a flushed stream are discarded, never buffered.
    assign push           = imem_resp_valid & ~redirect & (drop_q == '0);
    assign pop            = instruction_valid & ~stall & ~redirect;

    assign instruction_valid = (count_q != '0);
    assign instruction       = instruction_valid ? data_mem_q[rd_ptr_q] : NOP_INSTR;
    assign instruction_pc    = instruction_valid ? pc_mem_q[rd_ptr_q] : 32'h0;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;

        case ({req_fire, imem_resp_valid})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect) begin
            fetch_pc_d = target;
            resp_pc_d  = target;
            drop_d     = outstanding_d;
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)
                resp_pc_d = resp_pc_q + 32'd4;
            if (imem_resp_valid && drop_q != '0)
                drop_d = drop_q - CW'(1);
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_mem_d = data_mem_q;
        pc_mem_d   = pc_mem_q;

        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                data_mem_d[wr_ptr_q] = imem_resp_data;
                pc_mem_d[wr_ptr_q]   = resp_pc_q;
                wr_ptr_d             = wr_ptr_q + AW'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)
                count_d = count_q + CW'(1);
            else if (pop && !push)
                count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            count_q       <= '0;
            drop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clock) begin
        data_mem_q <= data_mem_d;
        pc_mem_q   <= pc_mem_d;
    end
endmodule
